bullet_pool: RTL and testbench



---
 rtl/bullet_pool.sv | 170 +++++++++++++++++
 tb/tb_bullet_pool.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// Bullet slot manager and per-pixel renderer: spawns, moves once per frame, retires off-screen bullets.
// Optional spawn throttling is enabled with `define BULLET_COOLDOWN_EN.
module bullet_pool #(
  parameter int NUM_SLOTS       = 10,
  parameter int SPEED           = 4,
  parameter int BULLET_W        = 8,
  parameter int BULLET_H        = 8,
  parameter int SCREEN_W        = 640,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic                   fire_req,
  input  logic [9:0]             fire_x,
  input  logic [9:0]             fire_y,
  input  logic                   fire_dir,
  input  logic                   clear_all,
  output logic                   fire_ack,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  output logic [NUM_SLOTS-1:0]   is_bullet,
  output logic [4*NUM_SLOTS-1:0] bullet_data,
  output logic [NUM_SLOTS-1:0]   slot_active
);

  localparam int CW = (BULLET_W > 1) ? $clog2(BULLET_W) : 1;
  localparam int RW = (BULLET_H > 1) ? $clog2(BULLET_H) : 1;
  localparam logic signed [10:0] STEP  = 11'(SPEED);
  localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - BULLET_W);

  logic [9:0]            pos_x [NUM_SLOTS];
  logic [9:0]            pos_y [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  dir;
  logic                  sync1, sync2, sync_prev;
  logic                  tick;
  logic                  found;
  logic [NUM_SLOTS-1:0]  spawn_sel;
  logic                  cool_ok;
  logic                  spawn_ok;
  logic signed [10:0]    next_x [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  retire;
  logic [NUM_SLOTS-1:0]  hit;
  logic [4*NUM_SLOTS-1:0] pix;

  function automatic logic [3:0] sprite_rom(input logic [RW-1:0] r, input logic [CW-1:0] c);
    int rr, cc;
    rr = int'(r);
    cc = int'(c);
    if ((rr == BULLET_H/2-1 || rr == BULLET_H/2) && (cc == BULLET_W/2-1 || cc == BULLET_W/2))
      sprite_rom = 4'd7;
    else if (((rr == 0 || rr == BULLET_H-1) && (cc < 2 || cc > BULLET_W-3)) ||
             ((rr == 1 || rr == BULLET_H-2) && (cc == 0 || cc == BULLET_W-1)))
      sprite_rom = 4'd0;
    else
      sprite_rom = 4'd15;
  endfunction

  // Synchroniser resets high so a frame_clk already high at release is not mistaken for a new edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= frame_clk;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign tick = sync2 & ~sync_prev;

`ifdef BULLET_COOLDOWN_EN
  localparam int CDW = $clog2(COOLDOWN_FRAMES + 1);
  logic [CDW-1:0] cooldown;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      cooldown <= '0;
    else if (clear_all)
      cooldown <= '0;
    else if (spawn_ok)
      cooldown <= CDW'(COOLDOWN_FRAMES);
    else if (tick && cooldown != '0)
      cooldown <= cooldown - 1'b1;
  end

  assign cool_ok = (cooldown == '0);
`else
  assign cool_ok = 1'b1;
`endif

  always_comb begin
    spawn_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_active[i] && !found) begin
        spawn_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign spawn_ok = fire_req && !clear_all && found && cool_ok;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      next_x[i] = dir[i] ? $signed({1'b0, pos_x[i]}) + STEP : $signed({1'b0, pos_x[i]}) - STEP;
      retire[i] = next_x[i][10] || (next_x[i] > X_MAX);
    end
  end

  // Spawn only targets an inactive slot, so it never collides with movement of the same slot.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slot_active <= '0;
      dir         <= '0;
      fire_ack    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
    end else begin
      fire_ack <= spawn_ok;
      if (clear_all) begin
        slot_active <= '0;
      end else begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (spawn_ok && spawn_sel[i]) begin
            slot_active[i] <= 1'b1;
            pos_x[i]       <= fire_x;
            pos_y[i]       <= fire_y;
            dir[i]         <= fire_dir;
          end else if (tick && slot_active[i]) begin
            if (retire[i])
              slot_active[i] <= 1'b0;
            else
              pos_x[i] <= next_x[i][9:0];
          end
        end
      end
    end
  end

  always_comb begin
    logic [10:0] dx, dy;
    hit = '0;
    pix = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      dx = {1'b0, DrawX} - {1'b0, pos_x[i]};
      dy = {1'b0, DrawY} - {1'b0, pos_y[i]};
      if (slot_active[i] && !dx[10] && !dy[10] && dx < 11'(BULLET_W) && dy < 11'(BULLET_H)) begin
        hit[i]       = 1'b1;
        pix[4*i +: 4] = sprite_rom(dy[RW-1:0], dx[CW-1:0]);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_bullet   <= '0;
      bullet_data <= '0;
    end else begin
      is_bullet   <= hit;
      bullet_data <= pix;
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Randomised and directed bench for bullet_pool, checked against a slot-list model kept in integers.
module tb_bullet_pool;

  localparam int N = 10;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         frame_clk = 1'b0;
  logic         fire_req = 1'b0;
  logic [9:0]   fire_x = '0;
  logic [9:0]   fire_y = '0;
  logic         fire_dir = 1'b0;
  logic         clear_all = 1'b0;
  logic         fire_ack;
  logic [9:0]   DrawX = '0;
  logic [9:0]   DrawY = '0;
  logic [N-1:0] is_bullet;
  logic [4*N-1:0] bullet_data;
  logic [N-1:0] slot_active;

  int vectors = 0;
  int miscompares = 0;

  int  mx [N];
  int  my [N];
  bit  mact [N];
  bit  mdir [N];
  bit  fhist [$];
  logic           exp_ack;
  logic [N-1:0]   exp_hit;
  logic [4*N-1:0] exp_data;

  bullet_pool dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire_req(fire_req),
    .fire_x(fire_x), .fire_y(fire_y), .fire_dir(fire_dir), .clear_all(clear_all),
    .fire_ack(fire_ack), .DrawX(DrawX), .DrawY(DrawY), .is_bullet(is_bullet),
    .bullet_data(bullet_data), .slot_active(slot_active)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Round sprite as a distance from the sprite centre: core, ring, transparent corners.
  function automatic logic [3:0] rom_ref(input int r, input int c);
    int d2;
    d2 = (2*c - 7) * (2*c - 7) + (2*r - 7) * (2*r - 7);
    if (d2 <= 2) return 4'd7;
    if (d2 > 60) return 4'd0;
    return 4'd15;
  endfunction

  function automatic bit hist_at(input int k);
    if (fhist.size() > k) return fhist[fhist.size()-1-k];
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mact[i] = 0; mx[i] = 0; my[i] = 0; mdir[i] = 0;
    end
    fhist.delete();
  endtask

  task automatic model_step();
    bit tk;
    int free, nx;
    fhist.push_back(frame_clk);
    tk = hist_at(2) && !hist_at(3);
    exp_hit = '0;
    exp_data = '0;
    for (int i = 0; i < N; i++) begin
      if (mact[i] && int'(DrawX) >= mx[i] && int'(DrawX) < mx[i] + 8 &&
          int'(DrawY) >= my[i] && int'(DrawY) < my[i] + 8) begin
        exp_hit[i] = 1'b1;
        exp_data[4*i +: 4] = rom_ref(int'(DrawY) - my[i], int'(DrawX) - mx[i]);
      end
    end
    exp_ack = 1'b0;
    if (clear_all) begin
      for (int i = 0; i < N; i++) mact[i] = 0;
    end else begin
      free = -1;
      for (int i = 0; i < N; i++)
        if (!mact[i] && free < 0) free = i;
      if (tk) begin
        for (int i = 0; i < N; i++) begin
          if (mact[i]) begin
            nx = mdir[i] ? mx[i] + 4 : mx[i] - 4;
            if (nx < 0 || nx > 632) mact[i] = 0;
            else mx[i] = nx;
          end
        end
      end
      if (fire_req && free >= 0) begin
        mact[free] = 1; mx[free] = int'(fire_x); my[free] = int'(fire_y); mdir[free] = fire_dir;
        exp_ack = 1'b1;
      end
    end
  endtask

  function automatic logic [N-1:0] model_mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = mact[i];
    return m;
  endfunction

  task automatic applyStimulus(input logic req, input logic [9:0] fx, input logic [9:0] fy,
                               input logic dir, input logic clr, input logic fclk,
                               input logic [9:0] dx, input logic [9:0] dy);
    fire_req = req; fire_x = fx; fire_y = fy; fire_dir = dir;
    clear_all = clr; frame_clk = fclk; DrawX = dx; DrawY = dy;
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    checkOutput("fire_ack", fire_ack, exp_ack);
    checkOutput("slot_active", slot_active, model_mask());
    checkOutput("is_bullet", is_bullet, exp_hit);
    checkOutput("bullet_data", bullet_data, exp_data);
  endtask

  task automatic idle(input logic fclk, input logic [9:0] dx, input logic [9:0] dy);
    applyStimulus(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, fclk, dx, dy);
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < 3; c++) idle(1'b1, 10'd0, 10'd0);
      for (int c = 0; c < 3; c++) idle(1'b0, 10'd0, 10'd0);
    end
  endtask

  task automatic clear_pool();
    applyStimulus(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
  endtask

  initial begin
    int fper, fcnt, s, px, py;
    logic fl;
    model_reset();
    repeat (3) @(negedge Clk);
    checkOutput("reset_active", slot_active, '0);
    checkOutput("reset_ack", fire_ack, 1'b0);
    checkOutput("reset_hit", is_bullet, '0);
    checkOutput("reset_data", bullet_data, '0);
    Reset_n = 1'b1;
    idle(1'b0, 10'd0, 10'd0);

    // Single spawn, then five frames of rightward motion.
    applyStimulus(1'b1, 10'd100, 10'd200, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    checkOutput("first_ack", fire_ack, 1'b1);
    checkOutput("first_mask", slot_active, 10'h001);
    frames(5);
    idle(1'b0, 10'd123, 10'd203);
    checkOutput("x120_centre_hit", is_bullet[0], 1'b1);
    checkOutput("x120_centre_data", bullet_data[3:0], 4'd7);
    idle(1'b0, 10'd119, 10'd203);
    checkOutput("x120_left_miss", is_bullet[0], 1'b0);
    idle(1'b0, 10'd120, 10'd203);
    checkOutput("x120_edge_data", bullet_data[3:0], 4'd15);

    // Eleven back-to-back requests: ten fill the pool, the last is dropped.
    clear_pool();
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b1, 10'(k * 50), 10'd300, 1'(k), 1'b0, 1'b0, 10'd0, 10'd0);
      if (k == 9) checkOutput("tenth_ack", fire_ack, 1'b1);
    end
    checkOutput("eleventh_ack", fire_ack, 1'b0);
    checkOutput("full_mask", slot_active, 10'h3FF);

    // Screen-edge retirement on both sides.
    clear_pool();
    applyStimulus(1'b1, 10'd2, 10'd50, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    frames(1);
    checkOutput("left_retire", slot_active, '0);
    applyStimulus(1'b1, 10'd628, 10'd50, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    frames(1);
    checkOutput("right_632_stays", slot_active, 10'h001);
    frames(1);
    checkOutput("right_636_retire", slot_active, '0);

    // Spawn in the same cycle as a tick.
    clear_pool();
    applyStimulus(1'b1, 10'd50, 10'd40, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    idle(1'b1, 10'd0, 10'd0);
    idle(1'b1, 10'd0, 10'd0);
    applyStimulus(1'b1, 10'd300, 10'd140, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
    idle(1'b0, 10'd57, 10'd43);
    checkOutput("moved_slot0_hit", is_bullet[0], 1'b1);
    checkOutput("moved_slot0_data", bullet_data[3:0], 4'd7);
    idle(1'b0, 10'd303, 10'd143);
    checkOutput("new_slot1_hit", is_bullet[1], 1'b1);
    checkOutput("new_slot1_data", bullet_data[7:4], 4'd7);

    // Pixel lookups around a bullet at (300,100).
    clear_pool();
    applyStimulus(1'b1, 10'd300, 10'd100, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    idle(1'b0, 10'd303, 10'd103);
    checkOutput("pix_centre_hit", is_bullet[0], 1'b1);
    checkOutput("pix_centre_data", bullet_data[3:0], 4'd7);
    idle(1'b0, 10'd300, 10'd100);
    checkOutput("pix_corner_hit", is_bullet[0], 1'b1);
    checkOutput("pix_corner_data", bullet_data[3:0], 4'd0);
    idle(1'b0, 10'd308, 10'd103);
    checkOutput("pix_outside_hit", is_bullet[0], 1'b0);

    // Asynchronous reset mid-frame with frame_clk held high.
    applyStimulus(1'b1, 10'd100, 10'd60, 1'b1, 1'b0, 1'b1, 10'd0, 10'd0);
    idle(1'b1, 10'd0, 10'd0);
    idle(1'b1, 10'd303, 10'd103);
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("midreset_active", slot_active, '0);
    checkOutput("midreset_ack", fire_ack, 1'b0);
    checkOutput("midreset_hit", is_bullet, '0);
    checkOutput("midreset_data", bullet_data, '0);
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    applyStimulus(1'b1, 10'd100, 10'd60, 1'b1, 1'b0, 1'b1, 10'd0, 10'd0);
    repeat (4) idle(1'b1, 10'd0, 10'd0);
    idle(1'b1, 10'd103, 10'd63);
    checkOutput("no_tick_after_reset", bullet_data[3:0], 4'd7);
    idle(1'b0, 10'd0, 10'd0);
    frames(1);

    // Randomised traffic.
    fl = 1'b0;
    fper = $urandom_range(3, 8);
    fcnt = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (++fcnt >= fper) begin
        fl = ~fl;
        fcnt = 0;
        fper = $urandom_range(3, 8);
      end
      s = $urandom_range(0, N-1);
      if ($urandom_range(0, 1) == 1 && mact[s]) begin
        px = mx[s] + $urandom_range(0, 11) - 2;
        py = my[s] + $urandom_range(0, 11) - 2;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
      end else begin
        px = $urandom_range(0, 639);
        py = $urandom_range(0, 479);
      end
      case ($urandom_range(0, 2))
        0: fire_x = 10'($urandom_range(0, 8));
        1: fire_x = 10'($urandom_range(624, 639));
        default: fire_x = 10'($urandom_range(0, 639));
      endcase
      applyStimulus($urandom_range(0, 2) == 0, fire_x, 10'($urandom_range(0, 479)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 59) == 0, fl,
                    10'(px), 10'(py));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
